npu_input_loader: RTL and testbench

Host-side frame loader directly upstream of the NPU top controller. Accepts a byte stream over a valid/ready handshake and parses framed commands. Drives the bias pair (BIAS_N1/BIAS_N2), pulses START, and delivers 4-lane input beats (DA..DD) to the input buffer over a second valid/ready handshake. Detects framing and timeout errors and keeps them as sticky flags.

---
 rtl/npu_input_loader.sv | 195 +++++++++++++++++++
 tb/tb_npu_input_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_input_loader.sv
// npu_input_loader: parses host byte frames (sync, count, 4 bias bytes, N 4-byte beats)
// into a bias pair, a START pulse and 4-lane input beats for the NPU input buffer.
module npu_input_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_BEATS = 64,
  parameter int         TIMEOUT   = 1000,
  parameter int         TO_W      = 16
) (
  input  logic        CLKEXT,
  input  logic        RST_GLO_N,
  input  logic [7:0]  HOST_DATA,
  input  logic        HOST_VALID,
  output logic        HOST_READY,
  input  logic        LANE_READY,
  output logic        LANE_VALID,
  output logic [7:0]  DA,
  output logic [7:0]  DB,
  output logic [7:0]  DC,
  output logic [7:0]  DD,
  output logic [15:0] BIAS_N1,
  output logic [15:0] BIAS_N2,
  output logic        START,
  output logic        BUSY,
  output logic        FRAME_DONE,
  input  logic        CLR_ERR,
  output logic [1:0]  ERR
);

  typedef enum logic [2:0] {S_HDR, S_CNT, S_BIAS, S_DATA, S_DRAIN} state_t;

  localparam logic [7:0]      MAX_B8 = 8'(MAX_BEATS);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_t               state_q, state_d;
  logic [1:0]           idx_q, idx_d;        // byte position within bias word / beat
  logic [7:0]           n_q, n_d;            // beats in this frame
  logic [7:0]           beat_q, beat_d;      // beats loaded so far
  logic [2:0][7:0]      stg_q, stg_d;        // first three bytes of a group
  logic [3:0][7:0]      lane_q, lane_d;      // [3]=byte0 ... [0]=byte3
  logic                 lane_vld_q, lane_vld_d;
  logic [15:0]          bias1_q, bias1_d, bias2_q, bias2_d;
  logic                 start_q, start_d, busy_q, busy_d, done_q, done_d;
  logic [1:0]           err_q, err_d, err_set;
  logic [TO_W-1:0]      to_q, to_d, to_inc;
  logic                 host_rdy, byte_acc, beat_acc, load;

  // Ready is only withheld on the beat-closing byte while the output beat is stuck.
  always_comb begin
    host_rdy = 1'b0;
    unique case (state_q)
      S_HDR, S_CNT, S_BIAS: host_rdy = 1'b1;
      S_DATA:               host_rdy = (idx_q != 2'd3) | ~lane_vld_q | LANE_READY;
      default:              host_rdy = 1'b0;
    endcase
  end

  // Gated by reset so the host sees no ready while the loader is held in reset.
  assign HOST_READY = host_rdy & RST_GLO_N;
  assign byte_acc   = HOST_VALID & host_rdy;
  assign beat_acc   = lane_vld_q & LANE_READY;
  assign to_inc     = to_q + TO_W'(1);

  // Next-state: frame parsing, beat assembly, idle timeout and sticky errors.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    n_d      = n_q;
    beat_d   = beat_q;
    stg_d    = stg_q;
    lane_d   = lane_q;
    bias1_d  = bias1_q;
    bias2_d  = bias2_q;
    busy_d   = busy_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    err_set  = 2'b00;
    to_d     = to_q;
    load     = 1'b0;

    unique case (state_q)
      S_HDR: if (byte_acc) begin
        if (HOST_DATA == SYNC_BYTE) state_d = S_CNT;
        else                        err_set[0] = 1'b1;
      end
      S_CNT: if (byte_acc) begin
        if (HOST_DATA != 8'd0 && HOST_DATA <= MAX_B8) begin
          n_d     = HOST_DATA;
          beat_d  = 8'd0;
          idx_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = S_BIAS;
        end else begin
          err_set[0] = 1'b1;
          state_d    = S_HDR;
        end
      end
      S_BIAS, S_DATA: if (byte_acc) begin
        if (idx_q == 2'd3) begin
          idx_d = 2'd0;
          if (state_q == S_BIAS) begin
            // All 32 bias bits land together with START
            bias1_d = {stg_q[0], stg_q[1]};
            bias2_d = {stg_q[2], HOST_DATA};
            start_d = 1'b1;
            state_d = S_DATA;
          end else begin
            load    = 1'b1;
            lane_d  = {stg_q[0], stg_q[1], stg_q[2], HOST_DATA};
            beat_d  = beat_q + 8'd1;
            if (beat_q + 8'd1 == n_q) state_d = S_DRAIN;
          end
        end else begin
          unique case (idx_q)
            2'd0:    stg_d[0] = HOST_DATA;
            2'd1:    stg_d[1] = HOST_DATA;
            default: stg_d[2] = HOST_DATA;
          endcase
          idx_d = idx_q + 2'd1;
        end
      end
      default: if (beat_acc) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_HDR;
      end
    endcase

    // Idle timeout only ticks when the loader is actually waiting on the host.
    if (state_q == S_CNT || state_q == S_BIAS || state_q == S_DATA) begin
      if (byte_acc) to_d = '0;
      else if (host_rdy) begin
        if (to_inc == TO_LIM) begin
          err_set[1] = 1'b1;
          state_d    = S_HDR;
          busy_d     = 1'b0;
          stg_d      = '0;
          idx_d      = 2'd0;
          to_d       = '0;
        end else to_d = to_inc;
      end
    end
    if (state_d != state_q) to_d = '0;

    lane_vld_d = load | (lane_vld_q & ~LANE_READY);
    err_d      = (CLR_ERR ? 2'b00 : err_q) | err_set;
  end

  // State and output registers.
  always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
    if (!RST_GLO_N) begin
      state_q    <= S_HDR;
      idx_q      <= 2'd0;
      n_q        <= 8'd0;
      beat_q     <= 8'd0;
      stg_q      <= '0;
      lane_q     <= '0;
      lane_vld_q <= 1'b0;
      bias1_q    <= 16'd0;
      bias2_q    <= 16'd0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 2'b00;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      beat_q     <= beat_d;
      stg_q      <= stg_d;
      lane_q     <= lane_d;
      lane_vld_q <= lane_vld_d;
      bias1_q    <= bias1_d;
      bias2_q    <= bias2_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      to_q       <= to_d;
    end
  end

  assign LANE_VALID = lane_vld_q;
  assign DA         = lane_q[3];
  assign DB         = lane_q[2];
  assign DC         = lane_q[1];
  assign DD         = lane_q[0];
  assign BIAS_N1    = bias1_q;
  assign BIAS_N2    = bias2_q;
  assign START      = start_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = done_q;
  assign ERR        = err_q;

endmodule

// File: tb/tb_npu_input_loader.sv
// Bench for npu_input_loader: directed frames plus randomized frames/backpressure,
// checked against a frame-level model (expected beats, bias, errors, counts).
module tb_npu_input_loader;
  logic        CLKEXT = 1'b0, RST_GLO_N = 1'b0;
  logic [7:0]  HOST_DATA = 8'd0;
  logic        HOST_VALID = 1'b0, HOST_READY, LANE_READY, LANE_VALID;
  logic [7:0]  DA, DB, DC, DD;
  logic [15:0] BIAS_N1, BIAS_N2;
  logic        START, BUSY, FRAME_DONE, CLR_ERR = 1'b0;
  logic [1:0]  ERR;

  npu_input_loader #(.TIMEOUT(8)) dut (
    .CLKEXT(CLKEXT), .RST_GLO_N(RST_GLO_N), .HOST_DATA(HOST_DATA), .HOST_VALID(HOST_VALID),
    .HOST_READY(HOST_READY), .LANE_READY(LANE_READY), .LANE_VALID(LANE_VALID),
    .DA(DA), .DB(DB), .DC(DC), .DD(DD), .BIAS_N1(BIAS_N1), .BIAS_N2(BIAS_N2),
    .START(START), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .CLR_ERR(CLR_ERR), .ERR(ERR));

  int vectors = 0, miscompares = 0, cyc = 0;
  int fd_cnt = 0, st_cnt = 0, exp_fd = 0, exp_st = 0, hr_drops = 0, last_acc = -10;
  logic [1:0]  exp_err = 2'b00;
  logic [15:0] exp_b1 = 16'd0, exp_b2 = 16'd0;
  logic        lr_rand = 1'b0, lr_val = 1'b1, hr_watch = 1'b0;
  logic [7:0]  fd [256];
  logic [31:0] exp_beats[$], got_q[$];
  int          acc_cyc[$];

  initial forever #5 CLKEXT = ~CLKEXT;
  initial forever begin @(posedge CLKEXT); cyc++; end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Downstream ready: either a held value or a coin flip every cycle.
  initial begin
    LANE_READY = 1'b1;
    forever begin
      @(posedge CLKEXT); #1;
      LANE_READY = lr_rand ? 1'($urandom_range(0, 1)) : lr_val;
    end
  end

  // Monitor: collects accepted beats and checks beat hold, START/bias and FRAME_DONE timing.
  initial begin
    logic        prev_hold = 1'b0;
    logic [31:0] prev_beat = 32'd0;
    forever begin
      @(negedge CLKEXT);
      if (!RST_GLO_N) prev_hold = 1'b0;
      else begin
        if (prev_hold) chk("beat_hold", {LANE_VALID, DA, DB, DC, DD}, {1'b1, prev_beat});
        prev_hold = LANE_VALID & ~LANE_READY;
        prev_beat = {DA, DB, DC, DD};
        if (hr_watch && !HOST_READY) hr_drops++;
        if (LANE_VALID && LANE_READY) begin
          got_q.push_back({DA, DB, DC, DD});
          acc_cyc.push_back(cyc);
          last_acc = cyc;
        end
        if (START) begin
          st_cnt++;
          chk("start_bias", {BIAS_N1, BIAS_N2}, {exp_b1, exp_b2});
        end
        if (FRAME_DONE) begin
          fd_cnt++;
          chk("done_latency", cyc - last_acc, 1);
          chk("done_busy", BUSY, 0);
        end
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int k);
    repeat (k) begin @(posedge CLKEXT); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    HOST_DATA = b; HOST_VALID = 1'b1;
    @(negedge CLKEXT);
    while (!HOST_READY && n < 300) begin @(negedge CLKEXT); n++; end
    if (!HOST_READY) chk("host_ready_wait", HOST_READY, 1);
    @(posedge CLKEXT); #1;
    HOST_VALID = 1'b0;
  endtask

  task automatic gap_wait(input int gap);
    if (gap > 0) idle($urandom_range(0, gap));
  endtask

  // Sends header, count, biases and the first nb data bytes of fd; models the whole frame.
  task automatic send_frame(input int n, input logic [15:0] b1, input logic [15:0] b2,
                            input int nb, input int gap);
    exp_b1 = b1; exp_b2 = b2; exp_st++;
    for (int i = 0; i < n; i++)
      exp_beats.push_back({fd[4*i], fd[4*i+1], fd[4*i+2], fd[4*i+3]});
    send_byte(8'hA5);  gap_wait(gap);
    send_byte(n[7:0]); gap_wait(gap);
    send_byte(b1[15:8]); gap_wait(gap);
    send_byte(b1[7:0]);  gap_wait(gap);
    send_byte(b2[15:8]); gap_wait(gap);
    send_byte(b2[7:0]);
    for (int i = 0; i < nb; i++) begin gap_wait(gap); send_byte(fd[i]); end
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < 4 * n; i++) fd[i] = 8'($urandom);
  endtask

  task automatic wait_done();
    int n = 0;
    exp_fd++;
    while (fd_cnt < exp_fd && n < 600) begin @(posedge CLKEXT); n++; end
    #1;
    chk("frame_done_seen", fd_cnt, exp_fd);
  endtask

  task automatic check_frame();
    chk("beat_count", got_q.size(), exp_beats.size());
    for (int i = 0; i < got_q.size() && i < exp_beats.size(); i++)
      chk("beat_data", got_q[i], exp_beats[i]);
    chk("frame_err", ERR, exp_err);
    chk("frame_busy", BUSY, 0);
    chk("start_count", st_cnt, exp_st);
    got_q.delete(); exp_beats.delete();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_ctl", {HOST_READY, LANE_VALID, START, BUSY, FRAME_DONE, ERR}, 0);
    chk("rst_lanes", {DA, DB, DC, DD}, 0);
    chk("rst_bias", {BIAS_N1, BIAS_N2}, 0);
    @(posedge CLKEXT); #1; RST_GLO_N = 1'b1;
    idle(1);

    // 1: single-beat frame
    fd[0] = 8'h11; fd[1] = 8'h22; fd[2] = 8'h33; fd[3] = 8'h44;
    send_frame(1, 16'h1234, 16'h5678, 4, 0);
    wait_done(); check_frame();

    // 2: three beats back to back, no host stall, 4-cycle beat spacing
    fill(3); acc_cyc.delete(); hr_watch = 1'b1;
    send_frame(3, 16'hA1B2, 16'hC3D4, 12, 0);
    hr_watch = 1'b0;
    wait_done();
    chk("hr_drops", hr_drops, 0);
    chk("beat_gap_n", acc_cyc.size(), 3);
    for (int i = 1; i < acc_cyc.size(); i++) chk("beat_gap", acc_cyc[i] - acc_cyc[i-1], 4);
    check_frame();

    // 3: backpressure on beat 2 byte 3
    lr_val = 1'b0; idle(2); fill(2); acc_cyc.delete();
    send_frame(2, 16'h0F0F, 16'hF0F0, 7, 0);
    HOST_DATA = fd[7]; HOST_VALID = 1'b1;
    repeat (10) begin @(negedge CLKEXT); chk("bp_ready", HOST_READY, 0); end
    chk("bp_no_timeout", {BUSY, ERR}, {1'b1, 2'b00});
    lr_val = 1'b1;
    @(posedge CLKEXT); #2;
    @(negedge CLKEXT); chk("bp_release_ready", HOST_READY, 1);
    @(posedge CLKEXT); #1; HOST_VALID = 1'b0;
    @(negedge CLKEXT); chk("bp_beat2", {LANE_VALID, DA, DB, DC, DD}, {1'b1, fd[4], fd[5], fd[6], fd[7]});
    @(posedge CLKEXT); #1;
    wait_done();
    chk("bp_beat_spacing", acc_cyc.size() == 2 ? acc_cyc[1] - acc_cyc[0] : -1, 1);
    check_frame();

    // 4: framing errors (bad sync, N=0, N=MAX_BEATS+1), then clear
    send_byte(8'h3C);
    @(negedge CLKEXT); chk("err_sync", ERR, 2'b01);
    @(posedge CLKEXT); #1;
    send_byte(8'hA5); send_byte(8'h00);
    @(negedge CLKEXT); chk("err_n0", {BUSY, ERR}, {1'b0, 2'b01});
    @(posedge CLKEXT); #1;
    send_byte(8'hA5); send_byte(8'd65);
    @(negedge CLKEXT); chk("err_n65", {BUSY, ERR}, {1'b0, 2'b01});
    chk("err_no_start", st_cnt, exp_st);
    @(posedge CLKEXT); #1; CLR_ERR = 1'b1;
    @(posedge CLKEXT); #1; CLR_ERR = 1'b0;
    @(negedge CLKEXT); chk("err_clear", ERR, 2'b00);
    @(posedge CLKEXT); #1;

    // N = MAX_BEATS is accepted
    fill(64);
    send_frame(64, 16'h4000, 16'h0040, 256, 0);
    wait_done(); check_frame();

    // 5: timeout after 8 idle cycles in BIAS
    send_byte(8'hA5); send_byte(8'h02);
    repeat (7) @(posedge CLKEXT);
    @(negedge CLKEXT); chk("to_before", {BUSY, ERR}, {1'b1, 2'b00});
    @(posedge CLKEXT);
    @(negedge CLKEXT); chk("to_fire", {BUSY, ERR}, {1'b0, 2'b10});
    chk("to_bias_kept", {BIAS_N1, BIAS_N2}, {exp_b1, exp_b2});
    exp_err = 2'b10;
    @(posedge CLKEXT); #1;
    fill(1);
    send_frame(1, 16'h7777, 16'h8888, 4, 0);
    wait_done(); check_frame();
    // set wins over simultaneous clear
    HOST_DATA = 8'h3C; HOST_VALID = 1'b1; CLR_ERR = 1'b1;
    @(posedge CLKEXT); #1; HOST_VALID = 1'b0; CLR_ERR = 1'b0;
    @(negedge CLKEXT); chk("err_set_wins", ERR, 2'b01);
    @(posedge CLKEXT); #1; CLR_ERR = 1'b1;
    @(posedge CLKEXT); #1; CLR_ERR = 1'b0; exp_err = 2'b00;

    // 6: reset during DATA beat 1 byte 2
    fill(1);
    send_frame(1, 16'hBEEF, 16'hCAFE, 2, 0);
    RST_GLO_N = 1'b0; #1;
    chk("mid_rst_ctl", {HOST_READY, LANE_VALID, START, BUSY, FRAME_DONE, ERR}, 0);
    chk("mid_rst_data", {DA, DB, DC, DD, BIAS_N1, BIAS_N2}, 0);
    exp_beats.delete(); got_q.delete();
    @(posedge CLKEXT); #1; RST_GLO_N = 1'b1;
    fill(2);
    send_frame(2, 16'h1357, 16'h2468, 8, 0);
    wait_done(); check_frame();

    // Randomized frames with host gaps, junk bytes and random downstream ready
    lr_rand = 1'b1;
    repeat (12) begin
      int n;
      logic [7:0] junk;
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk);
        exp_err[0] = 1'b1;
      end
      n = $urandom_range(1, 6);
      fill(n);
      send_frame(n, 16'($urandom), 16'($urandom), 4 * n, 3);
      wait_done(); check_frame();
    end
    lr_rand = 1'b0; lr_val = 1'b1;
    idle(3);
    chk("final_err", ERR, exp_err);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timed out");
  end
endmodule
